// File: rtl/imem_resp_pkg.sv
// imem_resp_pkg: shared definitions for the instruction-memory responder.
//   IMEM_NOP        - instruction returned for a faulting fetch (addi x0,x0,0)
//   IMEM_BASE       - default byte address of memory word 0
//   imem_entry_t    - {inst, err} bundle carried by delay-line stages and FIFO entries
//   imem_make_entry - builds an imem_entry_t from its fields
package imem_resp_pkg;

    localparam logic [31:0] IMEM_NOP  = 32'h0000_0013;
    localparam logic [31:0] IMEM_BASE = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } imem_entry_t;

    localparam int IMEM_ENTRY_W = $bits(imem_entry_t);

    function automatic imem_entry_t imem_make_entry(input logic [31:0] inst, input logic err);
        imem_entry_t e;
        e.inst = inst;
        e.err  = err;
        return e;
    endfunction

endpackage

// File: rtl/imem_resp_if.sv
// imem_resp_if: fetch request/response bundle between the core (master) and the
// instruction-memory responder (slave).
//   req_valid/req_ready/req_addr       - fetch request handshake, byte address
//   resp_valid/resp_ready              - response handshake
//   resp_inst/resp_err                 - returned instruction word and fault flag
interface imem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/imem_fifo.sv
// imem_fifo: synchronous FIFO, power-of-two depth.
//   clk, rst   - rising-edge clock, synchronous active-high reset (clears pointers/count only)
//   push       - write push_data at the tail (ignored when full)
//   pop        - drop the head entry (ignored when empty)
//   full/empty - status, count - number of stored entries
//   head       - entry at the head of the queue
module imem_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [W-1:0]  storage_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign head      = storage_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            storage_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/imem_resp.sv
// imem_resp: instruction-memory responder at the memory end of the fetch port.
//   clk, rst                - rising-edge clock, synchronous active-high reset
//   bus (slave)             - fetch request / response handshake (see imem_resp_if)
//   ld_wen/ld_addr/ld_data  - preload write port (word address), usable at any time
// Requests are decoded and the memory read at the accept edge, carried through a
// LATENCY-stage delay line and pushed into a response FIFO. req_ready admits a
// request only while (in-flight + buffered) < FIFO_DEPTH, so the delay line never
// stalls and the FIFO never overflows. Memory contents survive reset.
module imem_resp
    import imem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = IMEM_BASE,
    parameter int          AW         = 10,
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    imem_resp_if.slave    bus,
    input  logic          ld_wen,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int N_WORDS = 2 ** AW;

    logic [31:0]             mem_r [N_WORDS];
    logic [31:0]             offset_s;
    logic [31:0]             hi_s;
    logic                    err_s;
    logic [AW-1:0]           idx_s;
    imem_entry_t             rd_entry_s;
    logic                    accept_s;
    logic                    pop_s;
    logic                    push_s;
    logic [LATENCY-1:0]      dl_valid_r;
    imem_entry_t             dl_data_r [LATENCY];
    logic [CW-1:0]           dl_cnt_s;
    logic [CW-1:0]           occ_s;
    logic [CW-1:0]           occ_next_s;
    logic                    req_ready_r;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CW-1:0]           fifo_count_s;
    logic [IMEM_ENTRY_W-1:0] fifo_head_bits_s;
    imem_entry_t             head_s;

    assign accept_s = bus.req_valid && req_ready_r;
    assign pop_s    = bus.resp_ready && !fifo_empty_s;
    assign push_s   = dl_valid_r[LATENCY-1] && !fifo_full_s;

    // Address decode: misaligned, below base, or past the last word all fault;
    // a faulting fetch yields a nop and never touches the memory array.
    always_comb begin
        offset_s = bus.req_addr - BASE_ADDR;
        hi_s     = offset_s >> (AW + 2);
        err_s    = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) || (hi_s != 32'd0);
        idx_s    = offset_s[AW+1:2];
        if (err_s) begin
            rd_entry_s = imem_make_entry(IMEM_NOP, 1'b1);
        end else begin
            rd_entry_s = imem_make_entry(mem_r[idx_s], 1'b0);
        end
    end

    // Preload port; the array has no reset. A same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Delay-line payload: captured at the accept edge and shifted every cycle.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            dl_data_r[0] <= rd_entry_s;
        end
        for (int i = 1; i < LATENCY; i++) begin
            dl_data_r[i] <= dl_data_r[i-1];
        end
    end

    // Occupancy after this edge: in-flight stages plus buffered responses,
    // adjusted for this cycle's accept and pop.
    always_comb begin
        dl_cnt_s = {CW{1'b0}};
        for (int i = 0; i < LATENCY; i++) begin
            dl_cnt_s = dl_cnt_s + CW'(dl_valid_r[i]);
        end
        occ_s = dl_cnt_s + fifo_count_s;
        case ({accept_s, pop_s})
            2'b10:   occ_next_s = occ_s + CW'(1'b1);
            2'b01:   occ_next_s = occ_s - CW'(1'b1);
            default: occ_next_s = occ_s;
        endcase
    end

    // Delay-line valid bits and the registered ready; reset discards in-flight fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_r  <= {LATENCY{1'b0}};
            req_ready_r <= 1'b1;
        end else begin
            dl_valid_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1];
            end
            req_ready_r <= (occ_next_s < CW'(FIFO_DEPTH));
        end
    end

    imem_fifo #(
        .W     (IMEM_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (dl_data_r[LATENCY-1]),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_bits_s)
    );

    // Unreset FIFO storage is masked so an empty FIFO presents all-zero outputs.
    assign head_s         = imem_entry_t'(fifo_head_bits_s);
    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = !fifo_empty_s;
    assign bus.resp_inst  = fifo_empty_s ? 32'h0000_0000 : head_s.inst;
    assign bus.resp_err   = fifo_empty_s ? 1'b0 : head_s.err;

endmodule

// File: tb/tb_imem_resp.sv
`timescale 1ns/1ps
module tb_imem_resp;
    import imem_resp_pkg::*;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          AW     = 10;
    localparam int          NWORDS = 1024;
    localparam int          LAT    = 2;
    localparam int          DEPTH  = 4;

    typedef struct { logic [31:0] addr; logic [31:0] inst; logic err; } vec_t;
    typedef struct { logic [31:0] inst; logic err; } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_wen;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    imem_resp_if bus();

    imem_resp #(
        .BASE_ADDR  (BASE),
        .AW         (AW),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_wen  (ld_wen),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          acc_idx = 0;
    int          acc_cnt = 0;
    logic [31:0] ref_mem [NWORDS];
    exp_t        exp_q [$];
    logic [31:0] pop_inst_q [$];
    int          pop_idx_q [$];
    logic        acc_flag   = 1'b0;
    logic        pop_seen   = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] last_inst, prev_inst;
    logic        last_err, prev_err;
    logic [31:0] prog [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a fetch of this byte address must return, from the rules alone.
    function automatic exp_t ref_fetch(input logic [31:0] addr);
        exp_t r;
        if (addr[1:0] != 2'b00 || addr < BASE || (addr - BASE) >= 32'(4 * NWORDS)) begin
            r.inst = IMEM_NOP;
            r.err  = 1'b1;
        end else begin
            r.inst = ref_mem[int'((addr - BASE) >> 2)];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          sel = int'($urandom_range(0, 11));
        logic [31:0] a   = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
        case (sel)
            0:       a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 63));
            1:       a = BASE - 32'(4 * $urandom_range(1, 64));
            2:       a = a | 32'($urandom_range(1, 3));
            3:       a = $urandom();
            default: a = a;
        endcase
        return a;
    endfunction

    // Scoreboard step, taken at the falling edge: everything seen here is what the
    // next rising edge acts on. Queue holds accepted-but-not-returned fetches.
    task automatic sample();
        exp_t e;
        acc_flag = 1'b0;
        pop_seen = 1'b0;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("ready_vs_outstanding", bus.req_ready, (exp_q.size() < DEPTH));
            if (exp_q.size() == 0) check("no_stale_resp", bus.resp_valid, 1'b0);
            if (stall_prev) begin
                check("hold_valid", bus.resp_valid, 1'b1);
                check("hold_inst", bus.resp_inst, prev_inst);
                check("hold_err", bus.resp_err, prev_err);
            end
            if (bus.resp_valid && bus.resp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_inst", bus.resp_inst, e.inst);
                check("resp_err", bus.resp_err, e.err);
                pop_seen  = 1'b1;
                last_inst = bus.resp_inst;
                last_err  = bus.resp_err;
                pop_inst_q.push_back(bus.resp_inst);
                pop_idx_q.push_back(cyc);
            end
            if (bus.req_valid && bus.req_ready) begin
                exp_q.push_back(ref_fetch(bus.req_addr));
                acc_flag = 1'b1;
                acc_idx  = cyc;
                acc_cnt++;
            end
            stall_prev = bus.resp_valid && !bus.resp_ready;
            prev_inst  = bus.resp_inst;
            prev_err   = bus.resp_err;
        end
        if (ld_wen) ref_mem[ld_addr] = ld_data;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_wen  = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        tick();
        ld_wen  = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] addr, output logic [31:0] inst, output logic err,
                             output logic got);
        got  = 1'b0;
        inst = 32'h0;
        err  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            ld_wen = 1'b0;
            if (acc_flag) bus.req_valid = 1'b0;
            if (pop_seen) begin
                got  = 1'b1;
                inst = last_inst;
                err  = last_err;
            end
        end
        bus.req_valid = 1'b0;
        if (!got) check("fetch_timeout", got, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        logic [31:0] g_inst;
        logic        g_err;
        logic        got;
        int          first_acc;
        int          base_cnt;
        int          w;

        vecs[0] = '{32'h8000_0002, IMEM_NOP, 1'b1};
        vecs[1] = '{32'h8000_0004, 32'h0020_0113, 1'b0};
        vecs[2] = '{32'h7FFF_FFFC, IMEM_NOP, 1'b1};
        vecs[3] = '{32'h8000_0008, 32'h0030_0193, 1'b0};
        vecs[4] = '{32'h8000_1000, IMEM_NOP, 1'b1};
        vecs[5] = '{32'h8000_000C, 32'h0040_0213, 1'b0};
        vecs[6] = '{32'h8000_0FFF, IMEM_NOP, 1'b1};
        vecs[7] = '{32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h0010_0093, 1'b0};
        vecs[9] = '{32'h0000_0000, IMEM_NOP, 1'b1};

        rst = 1'b1; ld_wen = 1'b0; ld_addr = '0; ld_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = BASE; bus.resp_ready = 1'b0;
        tick();
        tick();
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_resp_valid", bus.resp_valid, 1'b0);
        check("reset_resp_inst", bus.resp_inst, 32'h0);
        check("reset_resp_err", bus.resp_err, 1'b0);
        rst = 1'b0;

        // Fill the whole array so every in-range fetch has a known word.
        for (int i = 0; i < NWORDS; i++) load(i, $urandom());
        for (int i = 0; i < 4; i++) load(i, prog[i]);
        load(5, 32'hAAAA_AAAA);
        load(1023, 32'hDEAD_BEEF);
        tick();

        // Ordered back-to-back fetch: first response LAT edges after its accept.
        pop_inst_q.delete();
        pop_idx_q.delete();
        first_acc = 0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = BASE + 32'(4 * i);
            tick();
            check("ordered_accept", acc_flag, 1'b1);
            if (i == 0) first_acc = acc_idx;
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("ordered_count", pop_inst_q.size(), 4);
        for (int i = 0; i < 4 && i < pop_inst_q.size(); i++) begin
            check($sformatf("ordered_inst%0d", i), pop_inst_q[i], prog[i]);
            // sample k precedes edge k; visible after edge k+LAT means sample k+LAT+1
            check($sformatf("ordered_cycle%0d", i), pop_idx_q[i], first_acc + LAT + 1 + i);
        end

        // Table of single fetches, faults interleaved with good fetches.
        foreach (vecs[i]) begin
            fetch_one(vecs[i].addr, g_inst, g_err, got);
            if (got) begin
                check($sformatf("vec%0d_inst", i), g_inst, vecs[i].inst);
                check($sformatf("vec%0d_err", i), g_err, vecs[i].err);
            end
        end

        // Same-edge preload and fetch of word 5: old data first, new data next.
        ld_wen = 1'b1; ld_addr = AW'(5); ld_data = 32'h5555_5555;
        fetch_one(BASE + 32'h14, g_inst, g_err, got);
        check("collision_old", g_inst, 32'hAAAA_AAAA);
        fetch_one(BASE + 32'h14, g_inst, g_err, got);
        check("collision_new", g_inst, 32'h5555_5555);

        // Backpressure: exactly DEPTH accepts, then drain in order.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = BASE + 32'h28;
        base_cnt       = acc_cnt;
        pop_inst_q.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (acc_flag) bus.req_addr = bus.req_addr + 32'h4;
        end
        check("bp_accepts", acc_cnt - base_cnt, DEPTH);
        check("bp_ready_low", bus.req_ready, 1'b0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("bp_drained", pop_inst_q.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < pop_inst_q.size(); i++) begin
            w = 10 + i;
            check($sformatf("bp_order%0d", i), pop_inst_q[i], ref_mem[w]);
        end
        check("bp_ready_back", bus.req_ready, 1'b1);

        // Reset with three fetches outstanding.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        base_cnt       = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = BASE + 32'(4 * i);
            tick();
        end
        check("mid_accepts", acc_cnt - base_cnt, 3);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_resp_valid", bus.resp_valid, 1'b0);
        check("mid_req_ready", bus.req_ready, 1'b1);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        fetch_one(BASE + 32'h4, g_inst, g_err, got);
        check("mid_mem_kept", g_inst, 32'h0020_0113);

        // Random traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.req_addr   = rand_addr();
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            ld_wen         = ($urandom_range(0, 5) == 0);
            ld_addr        = AW'($urandom_range(0, NWORDS - 1));
            if ($urandom_range(0, 2) == 0) ld_addr = bus.req_addr[AW+1:2];
            ld_data        = $urandom();
            tick();
        end
        bus.req_valid  = 1'b0;
        ld_wen         = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("rand_drain", exp_q.size(), 0);
        tick();
        check("rand_idle_valid", bus.resp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_resp.md
# imem_resp

Instruction-memory responder: the memory end of the core's fetch interface. It accepts fetch requests (byte address, word-aligned) over a valid/ready handshake and returns 32-bit instruction words in request order after a fixed pipeline latency, with an error flag for misaligned or out-of-range fetches. A separate write port lets the testbench or boot loader preload program words. Memory contents are not reset.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `AW`, default 10: word-address width; memory holds 2^AW words.
- `LATENCY`, default 2 (legal 1–4): cycles from request accept to response entering the output buffer.
- `FIFO_DEPTH`, default 4 (power of two, ≥ LATENCY+1): total outstanding capacity.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted this cycle when both valid and ready are high.
- `req_addr`  in  32  fetch byte address (the core's pc).
- `resp_valid`  out  1  response word available.
- `resp_ready`  in  1  consumer takes the response when both valid and ready are high.
- `resp_inst`  out  32  instruction word.
- `resp_err`  out  1  fetch was misaligned or out of range.
- `ld_wen`  in  1  preload write enable.
- `ld_addr`  in  AW  preload word address.
- `ld_data`  in  32  preload data.

## Operation
- Accept: `req_valid && req_ready`. Word index = (req_addr − BASE_ADDR) >> 2.
- Error cases:
  - req_addr[1:0] ≠ 0 → err.
  - Offset ≥ 4·2^AW, or req_addr < BASE_ADDR → err.
  - An errored response carries inst = 32'h0000_0013 (nop) and resp_err=1.
  - Memory is not read for an errored request.
- Read is sampled at the accept edge. Tagged with err, the result travels through a LATENCY-stage valid-tagged delay line, then is pushed into the response FIFO.
- Ordering: responses are returned strictly in accept order. There are no drops and no duplicates.
- Occupancy:
  - occ = (valid stages in delay line) + (FIFO count).
  - req_ready = (occ < FIFO_DEPTH).
  - Because of this rule, the delay line never stalls and a FIFO push never overflows.
- Response side: resp_valid = FIFO not empty. resp_inst and resp_err show the FIFO head and hold stable while resp_valid && !resp_ready.
- Preload:
  - When ld_wen=1, ld_data is written at the clock edge.
  - If an accept hits the same word in the same cycle, it returns the old data (read-before-write).
  - Preload writes are independent of the handshake and are allowed at any time.
- Simultaneous FIFO push and pop: both take effect and the count is unchanged. A pop from an empty FIFO cannot occur.
- Reset mid-operation: the delay line and FIFO are flushed, and in-flight requests are discarded with no response. Memory contents are preserved.

## Timing
- Reset values:
  - req_ready=1.
  - resp_valid=0, resp_inst=0, resp_err=0.
  - All delay-line valid bits 0.
  - FIFO count 0.
- Latency: a request accepted at edge N is visible as resp_valid at cycle N+LATENCY, provided the FIFO was empty. Otherwise it is visible after all earlier responses have popped.
- Throughput: with resp_ready held at 1, the block sustains one accept and one response per cycle.
- req_ready is a registered function of occ only. It has no combinational path from req_valid or resp_ready.
- resp_valid, resp_inst and resp_err come directly from FIFO registers.

## Structure
- A shared package holds:
  - `IMEM_NOP` = 32'h0000_0013.
  - `IMEM_BASE` = 32'h8000_0000.
  - The struct/bundle {inst[31:0], err} used for delay-line stages and FIFO entries.
- One sub-module: `imem_fifo`, a synchronous FIFO.
  - Parameterised width and depth.
  - Ports: push, pop, full, empty, count, head data.
  - Reset clears the pointers only.
- Memory array, address decode, delay line and occupancy counter live in `imem_resp`.

## Test plan
- Ordered fetch:
  - Preload words 0..3 with 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213.
  - Request pc 32'h8000_0000, ...0004, ...0008, ...000C back-to-back, with resp_ready=1 and LATENCY=2.
  - Required: responses in that order starting 2 cycles after the first accept, one per cycle, err=0.
- Errors:
  - req_addr 32'h8000_0002 → inst 32'h0000_0013, err=1.
  - req_addr 32'h7FFF_FFFC → err=1.
  - req_addr BASE+4·2^AW → err=1.
  - A valid request immediately after any of these returns correct data.
- Backpressure:
  - Hold resp_ready=0 and drive req_valid=1 continuously.
  - Required: exactly FIFO_DEPTH (4) accepts, then req_ready=0.
  - Then release resp_ready=1: all 4 responses come out in order, resp_inst stays stable while stalled, and req_ready returns to 1.
- Write/read collision:
  - Word 5 holds 32'hAAAA_AAAA. Same cycle: ld_wen writes word 5 := 32'h5555_5555 and a request for 32'h8000_0014 is accepted.
  - Required: the response is 32'hAAAA_AAAA.
  - Required: the next request to the same address returns 32'h5555_5555.
- Reset mid-flight:
  - Assert rst for 1 cycle with 3 requests outstanding.
  - Required: resp_valid=0 and req_ready=1 the cycle after reset, and no stale responses ever appear.
  - Required: preloaded words are still readable.
